// File: rtl/iter_divider_pkg.sv
// Shared constants for the iterative divider: opcodes, FSM states and NZCV flag positions.
// Flag positions match the ALU and condition unit layout.
package iter_divider_pkg;

    localparam logic [3:0] DIV_U = 4'b0110;
    localparam logic [3:0] DIV_S = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/iter_divider_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Quotient bits shift into the low end of the dividend register as it empties.
module div_step
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor, so the shifted value needs one extra bit and the
    // trial MSB is a clean borrow indicator.
    always_comb begin
        shifted = {rem_i, dvd_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        qbit_o  = ~trial[WIDTH];
        rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_o   = {dvd_i[WIDTH-2:0], qbit_o};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for the DIV_U/DIV_S opcodes; stalls via busy and
// returns sign-corrected quotient, remainder and NZCV flags with a one-cycle done pulse.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic [3:0]       DivFlags
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
    logic             qneg_q, rneg_q, dz_q, ovf_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] quo_q, remo_q;
    logic [3:0]       flags_q;

    logic             acc_ok, sgn, a_neg, b_neg, is_ovf;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem, step_dvd;
    logic             step_q;
    logic [WIDTH-1:0] q_d, r_d;
    logic [3:0]       flags_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_i     (dvd_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .dvd_o     (step_dvd),
        .qbit_o    (step_q)
    );

    always_comb begin
        acc_ok = start && (ALUControl == DIV_U || ALUControl == DIV_S);
        sgn    = ALUControl[0];
        a_neg  = sgn & a[WIDTH-1];
        b_neg  = sgn & b[WIDTH-1];
        a_mag  = a_neg ? ('0 - a) : a;
        b_mag  = b_neg ? ('0 - b) : b;
        is_ovf = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

        // Divide-by-zero keeps |a| in the dividend register; re-signing it restores a.
        q_d = dz_q ? '1 : (qneg_q ? ('0 - dvd_q) : dvd_q);
        if (dz_q)
            r_d = rneg_q ? ('0 - dvd_q) : dvd_q;
        else
            r_d = rneg_q ? ('0 - rem_q) : rem_q;

        flags_d         = '0;
        flags_d[FLAG_N] = q_d[WIDTH-1];
        flags_d[FLAG_Z] = (q_d == '0);
        flags_d[FLAG_C] = 1'b0;
        flags_d[FLAG_V] = dz_q | ovf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            flags_q <= 4'b0100;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (acc_ok) begin
                            dvd_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            dz_q    <= (b == '0);
                            ovf_q   <= is_ovf;
                            busy_q  <= 1'b1;
                            state_q <= (b == '0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        rem_q <= step_rem;
                        dvd_q <= step_dvd;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1))
                            state_q <= DONE;
                    end
                    DONE: begin
                        quo_q   <= q_d;
                        remo_q  <= r_d;
                        flags_q <= flags_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Quotient  = quo_q;
    assign Remainder = remo_q;
    assign DivFlags  = flags_q;

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle restoring divider that takes over the 4'b0110 (unsigned) and 4'b0111 (signed) divide opcodes from the single-cycle ALU.
- Sits beside the ALU in the execute stage and receives the same operands a, b and the same ALUControl.
- Stalls the pipeline via busy, then delivers quotient and remainder plus NZCV flags in the ALU flag layout for the result mux and the condition unit.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort; returns to IDLE, no done.
- ALUControl  input  4  opcode; 0110 = unsigned, 0111 = signed; other codes with start are ignored.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- Quotient  output  WIDTH  held until next accepted start.
- Remainder  output  WIDTH  held until next accepted start.
- DivFlags  output  4  {neg, zero, carry, overflow} of Quotient.

Behaviour:
- Reset (async, any state): state = IDLE; busy = 0, done = 0, Quotient = 0, Remainder = 0, DivFlags = 4'b0100; counter and working registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accepts a request when start = 1 and ALUControl ∈ {0110, 0111}.
  - Latches a, b and the signed flag (ALUControl[0]).
  - Signed mode: stores magnitudes (two's-complement negate if MSB set) plus sign of quotient (a[31]^b[31]) and sign of remainder (a[31]).
  - b == 0 → DONE next cycle.
  - Else → RUN with counter = 0.
- RUN:
  - One restoring step per cycle: shift {rem, dvd} left 1; trial = rem - divisor; if trial non-negative, rem = trial and quotient bit = 1, else quotient bit = 0.
  - After WIDTH steps (counter == WIDTH-1) → DONE.
- DONE:
  - Quotient/Remainder registered with sign correction applied; done = 1 for exactly this cycle; → IDLE.
- Latency: start accepted at edge 0; done high in cycle WIDTH+1 (33 for WIDTH = 32). Divide-by-zero: done high in cycle 1.
- Back-to-back: start in the cycle after done is accepted. start while busy is ignored; no queuing.
- flush = 1 in any state → IDLE next edge, done stays 0, outputs keep old values. flush has priority over start and over DONE.
- Rounding: truncation toward zero; remainder takes the sign of the dividend.
- Divide by zero:
  - Quotient = all ones (0xFFFFFFFF, i.e. -1 signed).
  - Remainder = a.
  - DivFlags overflow = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): Quotient = 0x80000000, Remainder = 0, overflow = 1. Obtained naturally from magnitude arithmetic; no special path.
- DivFlags:
  - neg = Quotient[WIDTH-1].
  - zero = (Quotient == 0).
  - carry = 0.
  - overflow as defined above, else 0.
  - Updated in DONE only.

Decomposition:
- Shared package: opcode constants DIV_U = 4'b0110, DIV_S = 4'b0111; state encoding IDLE/RUN/DONE (2-bit); flag bit positions N=3, Z=2, C=1, V=0 (shared with the ALU and condition unit).
- Sub-module div_step (combinational, one restoring iteration):
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, q bit.
  - Keeps the FSM file focused on control.

Test Plan:
- Unsigned: a = 100, b = 7, 0110 → done in cycle 33, Quotient = 14, Remainder = 2, DivFlags = 0000.
- Signed: a = -100 (0xFFFFFF9C), b = 7, 0111 → Quotient = 0xFFFFFFF2 (-14), Remainder = 0xFFFFFFFE (-2), DivFlags = 1000.
- Divide by zero: a = 0x1234, b = 0 (either mode) → done in cycle 1, Quotient = 0xFFFFFFFF, Remainder = 0x1234, DivFlags = 1001.
- Signed overflow: a = 0x80000000, b = 0xFFFFFFFF, 0111 → Quotient = 0x80000000, Remainder = 0, DivFlags = 1001.
- Control:
  - start pulses every cycle during RUN → ignored, single done.
  - flush at cycle 10 → busy low next cycle, no done, previous Quotient retained.
  - reset asserted mid-RUN (asynchronously) → busy = 0, Quotient = 0 immediately.
- Back-to-back: 7/1 then start in the cycle after done with 0xFFFFFFFF/2 unsigned → results 7, then 0x7FFFFFFF with remainder 1.
